// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronised and glitch-filtered clock, 11-bit frame capture,
// and an E0/F0 prefix decoder that drives held flags for the arrow keys and space.
module ps2_keyboard #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 20_000
) (
  input  logic       i_clk,
  input  logic       i_clr,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_scan_code,
  output logic       o_scan_valid,
  output logic       o_scan_break,
  output logic       o_scan_ext,
  output logic       o_frame_err,
  output logic       o_key_up,
  output logic       o_key_down,
  output logic       o_key_left,
  output logic       o_key_right,
  output logic       o_key_space
);

  localparam int unsigned FW = $clog2(FILTER_LEN) + 1;
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK} state_t;
  state_t r_state, w_state_nxt;

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic [FW-1:0] r_filt_cnt;
  logic          r_fclk, r_fclk_q;
  logic          w_fall;
  logic [10:0]   r_shift;
  logic [3:0]    r_bitcnt;
  logic [WW-1:0] r_wdog;
  logic          r_ext_pend, r_brk_pend;
  logic          w_shift_en, w_first, w_timeout, w_accept, w_reject;
  logic          w_frame_ok;
  logic [7:0]    w_byte;

  // Synchronisers and filter idle high, matching the PS/2 bus idle level.
  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_filt_cnt <= '0;
      r_fclk     <= 1'b1;
      r_fclk_q   <= 1'b1;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= i_ps2_data;
      r_dat_s2 <= r_dat_s1;
      r_fclk_q <= r_fclk;
      if (r_clk_s2 == r_fclk) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FILT_MAX) begin
        r_fclk     <= r_clk_s2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  assign w_fall     = r_fclk_q & ~r_fclk;
  assign w_byte     = r_shift[8:1];
  assign w_frame_ok = ~r_shift[0] & r_shift[10] & (^r_shift[9:1]);

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    w_first     = 1'b0;
    w_timeout   = 1'b0;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_shift_en  = 1'b1;
          w_first     = 1'b1;
          w_state_nxt = S_RECV;
        end
      end
      S_RECV: begin
        if (w_fall) begin
          w_shift_en = 1'b1;
          if (r_bitcnt == 4'd10) w_state_nxt = S_CHECK;
        end else if (r_wdog == WD_MAX) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_CHECK: begin
        w_state_nxt = S_IDLE;
        if (w_frame_ok) w_accept = 1'b1;
        else            w_reject = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_shift      <= '0;
      r_bitcnt     <= '0;
      r_wdog       <= '0;
      r_ext_pend   <= 1'b0;
      r_brk_pend   <= 1'b0;
      o_scan_code  <= '0;
      o_scan_valid <= 1'b0;
      o_scan_break <= 1'b0;
      o_scan_ext   <= 1'b0;
      o_frame_err  <= 1'b0;
      o_key_up     <= 1'b0;
      o_key_down   <= 1'b0;
      o_key_left   <= 1'b0;
      o_key_right  <= 1'b0;
      o_key_space  <= 1'b0;
    end else begin
      o_scan_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      r_wdog       <= (r_state == S_RECV && !w_fall) ? r_wdog + 1'b1 : '0;
      if (w_shift_en) begin
        r_shift  <= {r_dat_s2, r_shift[10:1]};
        r_bitcnt <= w_first ? 4'd1 : r_bitcnt + 4'd1;
      end
      // A timeout keeps the pending prefixes; only a bad frame drops them.
      if (w_timeout || w_reject) o_frame_err <= 1'b1;
      if (w_reject) begin
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
      end
      if (w_accept) begin
        if (w_byte == 8'hE0) begin
          r_ext_pend <= 1'b1;
        end else if (w_byte == 8'hF0) begin
          r_brk_pend <= 1'b1;
        end else begin
          o_scan_code  <= w_byte;
          o_scan_break <= r_brk_pend;
          o_scan_ext   <= r_ext_pend;
          o_scan_valid <= 1'b1;
          r_ext_pend   <= 1'b0;
          r_brk_pend   <= 1'b0;
          if (r_ext_pend) begin
            case (w_byte)
              8'h75:   o_key_up    <= ~r_brk_pend;
              8'h72:   o_key_down  <= ~r_brk_pend;
              8'h6B:   o_key_left  <= ~r_brk_pend;
              8'h74:   o_key_right <= ~r_brk_pend;
              default: ;
            endcase
          end else if (w_byte == 8'h29) begin
            o_key_space <= ~r_brk_pend;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Bench for ps2_keyboard: scripted protocol vectors, timeout/reset sequences and a
// randomized tail checked against a prefix/key-map model of the keyboard protocol.
module tb_ps2_keyboard;

  localparam int FL = 8;
  localparam int TO = 20_000;
  localparam int HB = 30;

  logic       clk = 1'b0;
  logic       clr, ps2_clk, ps2_data;
  logic [7:0] scan_code;
  logic       scan_valid, scan_break, scan_ext, frame_err;
  logic       key_up, key_down, key_left, key_right, key_space;

  ps2_keyboard #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_clr(clr), .i_ps2_clk(ps2_clk), .i_ps2_data(ps2_data),
    .o_scan_code(scan_code), .o_scan_valid(scan_valid), .o_scan_break(scan_break),
    .o_scan_ext(scan_ext), .o_frame_err(frame_err),
    .o_key_up(key_up), .o_key_down(key_down), .o_key_left(key_left),
    .o_key_right(key_right), .o_key_space(key_space)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int n_sv = 0, n_fe = 0, n_both = 0;
  logic [7:0] mon_code = '0;
  logic       mon_brk = 1'b0, mon_ext = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (scan_valid) begin
      n_sv     <= n_sv + 1;
      mon_code <= scan_code;
      mon_brk  <= scan_break;
      mon_ext  <= scan_ext;
    end
    if (frame_err) n_fe <= n_fe + 1;
    if (scan_valid && frame_err) n_both <= n_both + 1;
  end

  function automatic logic [4:0] keys();
    return {key_up, key_down, key_left, key_right, key_space};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       bad;
    logic       glitch;
    logic       sv;
    logic       fe;
    logic [7:0] code;
    logic       brk;
    logic       ext;
    logic [4:0] keys;
  } vec_t;

  // Protocol model: pending prefixes plus held keys {up,down,left,right,space}.
  logic       m_ext = 1'b0, m_brk = 1'b0;
  logic [4:0] m_keys = '0;

  function automatic vec_t model(input logic [7:0] d, input logic bad);
    vec_t v;
    int   idx;
    v = '{d, bad, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'b0};
    if (bad) begin
      v.fe = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (d == 8'hE0) begin
      m_ext = 1'b1;
    end else if (d == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      v.sv = 1'b1; v.code = d; v.brk = m_brk; v.ext = m_ext;
      idx = -1;
      if (m_ext && d == 8'h75) idx = 4;
      if (m_ext && d == 8'h72) idx = 3;
      if (m_ext && d == 8'h6B) idx = 2;
      if (m_ext && d == 8'h74) idx = 1;
      if (!m_ext && d == 8'h29) idx = 0;
      if (idx >= 0) m_keys[idx] = ~m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    v.keys = m_keys;
    return v;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic bad, input logic glitch, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^d) ^ bad, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      if (glitch) begin
        repeat (8) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HB - 13) @(negedge clk);
      end else begin
        repeat (HB) @(negedge clk);
      end
      ps2_clk  = 1'b0;
      fall_cyc = cyc;
      repeat (HB) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int sv0, fe0;
    sv0 = n_sv;
    fe0 = n_fe;
    send_frame(v.d, v.bad, v.glitch, 11);
    repeat (20) @(negedge clk);
    chk($sformatf("scan_valid count d=%02h", v.d), n_sv - sv0, 32'(v.sv));
    chk($sformatf("frame_err count d=%02h", v.d), n_fe - fe0, 32'(v.fe));
    if (v.sv) begin
      chk("scan_code", 32'(mon_code), 32'(v.code));
      chk("scan_break", 32'(mon_brk), 32'(v.brk));
      chk("scan_ext", 32'(mon_ext), 32'(v.ext));
    end
    chk($sformatf("held keys d=%02h", v.d), 32'(keys()), 32'(v.keys));
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic bad, input logic gl, input logic sv,
                              input logic fe, input logic brk, input logic ext, input logic [4:0] k);
    vec_t v;
    v = '{d, bad, gl, sv, fe, d, brk, ext, k};
    return v;
  endfunction

  vec_t vt[$];

  initial begin
    vec_t v, tmp;
    int   sv0, fe0, got;
    logic [7:0] d;

    vt.push_back(mk(8'hE0, 0, 0, 0, 0, 0, 0, 5'b00000));
    vt.push_back(mk(8'h6B, 0, 0, 1, 0, 0, 1, 5'b00100));
    vt.push_back(mk(8'hE0, 0, 0, 0, 0, 0, 0, 5'b00100));
    vt.push_back(mk(8'hF0, 0, 0, 0, 0, 0, 0, 5'b00100));
    vt.push_back(mk(8'h6B, 0, 0, 1, 0, 1, 1, 5'b00000));
    vt.push_back(mk(8'h75, 0, 0, 1, 0, 0, 0, 5'b00000));
    vt.push_back(mk(8'hE0, 0, 0, 0, 0, 0, 0, 5'b00000));
    vt.push_back(mk(8'h75, 0, 0, 1, 0, 0, 1, 5'b10000));
    vt.push_back(mk(8'hE0, 0, 0, 0, 0, 0, 0, 5'b10000));
    vt.push_back(mk(8'h29, 1, 0, 0, 1, 0, 0, 5'b10000));
    vt.push_back(mk(8'h29, 0, 0, 1, 0, 0, 0, 5'b10001));
    vt.push_back(mk(8'hF0, 0, 0, 0, 0, 0, 0, 5'b10001));
    vt.push_back(mk(8'h29, 0, 0, 1, 0, 1, 0, 5'b10000));
    vt.push_back(mk(8'h29, 0, 1, 1, 0, 0, 0, 5'b10001));
    vt.push_back(mk(8'hE0, 0, 0, 0, 0, 0, 0, 5'b10001));
    vt.push_back(mk(8'h74, 0, 0, 1, 0, 0, 1, 5'b10011));
    vt.push_back(mk(8'hE0, 0, 0, 0, 0, 0, 0, 5'b10011));
    vt.push_back(mk(8'h72, 0, 0, 1, 0, 0, 1, 5'b11011));
    vt.push_back(mk(8'h33, 0, 0, 1, 0, 0, 0, 5'b11011));

    clr = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset outputs", 32'({scan_code, scan_valid, scan_break, scan_ext, frame_err, keys()}), 32'd0);
    clr = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle after reset", 32'({scan_valid, frame_err, keys()}), 32'd0);

    foreach (vt[i]) begin
      tmp = model(vt[i].d, vt[i].bad);
      run_vec(vt[i]);
    end

    // Timeout: five bits then silence; prefixes untouched, next frame decodes.
    sv0 = n_sv; fe0 = n_fe; got = -1;
    send_frame(8'h1C, 1'b0, 1'b0, 5);
    for (int i = 0; i < 25_000; i++) begin
      @(negedge clk);
      if (frame_err && got < 0) got = cyc - fall_cyc;
    end
    chk("timeout frame_err count", n_fe - fe0, 32'd1);
    chk("timeout no scan_valid", n_sv - sv0, 32'd0);
    checks++;
    if (got < TO + 5 || got > TO + 20) begin
      errors++;
      $display("FAIL timeout latency: got %0d cycles expected %0d..%0d", got, TO + 5, TO + 20);
    end
    run_vec(model(8'h1C, 1'b0));

    // Asynchronous reset mid-bit of a 6B frame while right arrow is held.
    chk("right held before reset", 32'(key_right), 32'd1);
    sv0 = n_sv; fe0 = n_fe;
    send_frame(8'h6B, 1'b0, 1'b0, 4);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (HB) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (12) @(negedge clk);
    #1 clr = 1'b1;
    #1 chk("async reset outputs", 32'({scan_code, scan_valid, scan_break, scan_ext, frame_err, keys()}), 32'd0);
    @(negedge clk);
    ps2_clk = 1'b1;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    m_ext = 1'b0; m_brk = 1'b0; m_keys = '0;
    repeat (30) @(negedge clk);
    chk("no strobe after reset", (n_sv - sv0) + (n_fe - fe0), 32'd0);
    run_vec(model(8'h6B, 1'b0));

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    d = 8'hE0;
        2:       d = 8'hF0;
        3:       d = 8'h75;
        4:       d = 8'h72;
        5:       d = 8'h6B;
        6:       d = 8'h74;
        7:       d = 8'h29;
        default: d = 8'($urandom_range(0, 255));
      endcase
      v = model(d, ($urandom_range(0, 7) == 0));
      run_vec(v);
    end

    chk("scan_valid and frame_err never together", n_both, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
